// File: rtl/vrf_pkg.sv
// ---------------------------------------------------------------------------
// vrf_pkg
//   Shared definitions for the vector register file:
//     - clear-FSM state encoding (IDLE, CLEAR, DONE)
//     - default LANES / ELEM_WIDTH / REG_COUNT values
//     - lane_lsb(): bit offset of a lane inside a packed vector register
//   Optional feature macro used by the top: VRF_WRITE_BYPASS_EN
// ---------------------------------------------------------------------------
package vrf_pkg;

    localparam int VRF_LANES      = 4;
    localparam int VRF_ELEM_WIDTH = 8;
    localparam int VRF_REG_COUNT  = 8;
    localparam int VRF_SEL_BITS   = $clog2(VRF_REG_COUNT);

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_e;

    // Lane i of a vector register lives at [lane_lsb(i, w) +: w].
    function automatic int lane_lsb(input int lane, input int elem_width);
        return lane * elem_width;
    endfunction

endpackage

// File: rtl/vrf_scoreboard.sv
// ---------------------------------------------------------------------------
// vrf_scoreboard
//   Pending-write scoreboard for the vector register file. One pending bit
//   per register: set when an instruction issues with that destination,
//   cleared by its writeback or by the bulk-clear sequencer.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   issue_en_i        decoder requests issue
//   issue_dst_i       destination of the issuing instruction
//   issue_src1_i/2_i  sources of the issuing instruction
//   wb_en_i           writeback accepted this cycle (already gated by clear)
//   wb_sel_i          writeback destination
//   clr_en_i          bulk clear is wiping register clr_sel_i this cycle
//   clr_sel_i         register being wiped
//   block_i           unconditional stall (bulk clear in progress)
//   stall_o           issue refused this cycle (combinational)
// ---------------------------------------------------------------------------
module vrf_scoreboard #(
    parameter int REG_COUNT = 8,
    parameter int SEL_BITS  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_en_i,
    input  logic [SEL_BITS-1:0] issue_dst_i,
    input  logic [SEL_BITS-1:0] issue_src1_i,
    input  logic [SEL_BITS-1:0] issue_src2_i,
    input  logic                wb_en_i,
    input  logic [SEL_BITS-1:0] wb_sel_i,
    input  logic                clr_en_i,
    input  logic [SEL_BITS-1:0] clr_sel_i,
    input  logic                block_i,
    output logic                stall_o
);

    logic [REG_COUNT-1:0] pending_q;
    logic [REG_COUNT-1:0] pending_d;
    logic [REG_COUNT-1:0] wb_onehot;
    logic [REG_COUNT-1:0] pending_eff;

    always_comb begin
        wb_onehot = '0;
        if (wb_en_i) begin
            wb_onehot[wb_sel_i] = 1'b1;
        end

        // A writeback landing this cycle resolves its hazard right now,
        // so its register is already treated as free for the stall check.
        pending_eff = pending_q & ~wb_onehot;

        stall_o = block_i |
                  (issue_en_i & (pending_eff[issue_src1_i] |
                                 pending_eff[issue_src2_i] |
                                 pending_eff[issue_dst_i]));

        pending_d = pending_eff;
        if (clr_en_i) begin
            pending_d[clr_sel_i] = 1'b0;
        end
        // Applied last: a new producer issuing on the same edge as the old
        // producer's writeback keeps the register pending.
        if (issue_en_i && !stall_o) begin
            pending_d[issue_dst_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/vector_register_file.sv
// ---------------------------------------------------------------------------
// vector_register_file
//   REG_COUNT vector registers of LANES x ELEM_WIDTH bits with per-lane
//   masked writeback, two combinational read ports, a pending-write
//   scoreboard with issue stall, and a sequenced bulk-clear FSM.
//
// Optional feature: define VRF_WRITE_BYPASS_EN to forward same-cycle
//   writeback data (masked lanes only) onto a read port selecting the
//   register being written.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   wr_en/wr_sel/wr_mask/wr_data   writeback; lane i at [i*ELEM_WIDTH +: ELEM_WIDTH]
//   rd_sel1/rd_sel2            read selects
//   rd1_data/rd2_data          read data (combinational)
//   issue_en/issue_dst/issue_src1/issue_src2   issue request
//   stall                      issue refused this cycle
//   clr_req                    start bulk clear
//   clr_busy                   bulk clear in progress (CLEAR and DONE)
//   clr_done                   one-cycle pulse in DONE
//   clr_state                  debug view of the clear-FSM state
//
// Handshake: issue is accepted on a rising edge where issue_en=1 and
//   stall=0; writeback is accepted on a rising edge where wr_en=1 and
//   clr_busy=0 (otherwise it is dropped, there is no retry).
// ---------------------------------------------------------------------------
module vector_register_file
    import vrf_pkg::*;
#(
    parameter int LANES      = VRF_LANES,
    parameter int ELEM_WIDTH = VRF_ELEM_WIDTH,
    parameter int REG_COUNT  = VRF_REG_COUNT,
    parameter int SEL_BITS   = VRF_SEL_BITS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [SEL_BITS-1:0]         wr_sel,
    input  logic [LANES-1:0]            wr_mask,
    input  logic [LANES*ELEM_WIDTH-1:0] wr_data,
    input  logic [SEL_BITS-1:0]         rd_sel1,
    input  logic [SEL_BITS-1:0]         rd_sel2,
    output logic [LANES*ELEM_WIDTH-1:0] rd1_data,
    output logic [LANES*ELEM_WIDTH-1:0] rd2_data,
    input  logic                        issue_en,
    input  logic [SEL_BITS-1:0]         issue_dst,
    input  logic [SEL_BITS-1:0]         issue_src1,
    input  logic [SEL_BITS-1:0]         issue_src2,
    output logic                        stall,
    input  logic                        clr_req,
    output logic                        clr_busy,
    output logic                        clr_done,
    output logic [1:0]                  clr_state
);

    localparam int VW = LANES * ELEM_WIDTH;
    localparam logic [SEL_BITS-1:0] LAST_REG = SEL_BITS'(REG_COUNT - 1);

    logic [VW-1:0]       regs_q [REG_COUNT];
    logic [VW-1:0]       regs_d [REG_COUNT];
    clr_state_e          state_q, state_d;
    logic [SEL_BITS-1:0] cnt_q, cnt_d;
    logic                clr_active;
    logic                wr_fire;

    // Replace the lanes of old_v selected by mask with those of new_v.
    function automatic logic [VW-1:0] merge_lanes(input logic [VW-1:0]    old_v,
                                                  input logic [VW-1:0]    new_v,
                                                  input logic [LANES-1:0] mask);
        logic [VW-1:0] res;
        res = old_v;
        for (int l = 0; l < LANES; l++) begin
            if (mask[l]) begin
                res[lane_lsb(l, ELEM_WIDTH) +: ELEM_WIDTH] =
                    new_v[lane_lsb(l, ELEM_WIDTH) +: ELEM_WIDTH];
            end
        end
        return res;
    endfunction

    // ---------------- clear FSM ----------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_busy   = 1'b0;
        clr_done   = 1'b0;
        clr_active = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_d = CLR_CLEAR;
                    cnt_d   = '0;
                end
            end
            CLR_CLEAR: begin
                clr_busy   = 1'b1;
                clr_active = 1'b1;
                cnt_d      = cnt_q + 1'b1;
                // Leave before the counter could wrap past the last register.
                if (cnt_q == LAST_REG) begin
                    state_d = CLR_DONE;
                end
            end
            CLR_DONE: begin
                clr_busy = 1'b1;
                clr_done = 1'b1;
                state_d  = CLR_IDLE;
            end
            default: begin
                state_d = CLR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clr_state = state_q;

    // ---------------- storage ----------------
    assign wr_fire = wr_en & ~clr_busy;

    always_comb begin
        for (int r = 0; r < REG_COUNT; r++) begin
            regs_d[r] = regs_q[r];
        end
        if (wr_fire) begin
            regs_d[wr_sel] = merge_lanes(regs_q[wr_sel], wr_data, wr_mask);
        end
        if (clr_active) begin
            regs_d[cnt_q] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < REG_COUNT; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    // ---------------- read ports ----------------
    always_comb begin
        rd1_data = regs_q[rd_sel1];
        rd2_data = regs_q[rd_sel2];
`ifdef VRF_WRITE_BYPASS_EN
        if (wr_fire && (rd_sel1 == wr_sel)) begin
            rd1_data = merge_lanes(regs_q[rd_sel1], wr_data, wr_mask);
        end
        if (wr_fire && (rd_sel2 == wr_sel)) begin
            rd2_data = merge_lanes(regs_q[rd_sel2], wr_data, wr_mask);
        end
`else
        // Without forwarding, written data appears the cycle after the edge.
`endif
    end

    // ---------------- scoreboard ----------------
    vrf_scoreboard #(
        .REG_COUNT (REG_COUNT),
        .SEL_BITS  (SEL_BITS)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .issue_en_i   (issue_en),
        .issue_dst_i  (issue_dst),
        .issue_src1_i (issue_src1),
        .issue_src2_i (issue_src2),
        .wb_en_i      (wr_fire),
        .wb_sel_i     (wr_sel),
        .clr_en_i     (clr_active),
        .clr_sel_i    (cnt_q),
        .block_i      (clr_busy),
        .stall_o      (stall)
    );

endmodule

// File: tb/tb_vector_register_file.sv
module tb_vector_register_file;
  import vrf_pkg::*;

  localparam int LANES = 4;
  localparam int EW    = 8;
  localparam int RC    = 8;
  localparam int SB    = 3;
  localparam int VW    = LANES * EW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en;
  logic [SB-1:0] wr_sel;
  logic [LANES-1:0] wr_mask;
  logic [VW-1:0] wr_data;
  logic [SB-1:0] rd_sel1, rd_sel2;
  logic [VW-1:0] rd1_data, rd2_data;
  logic          issue_en;
  logic [SB-1:0] issue_dst, issue_src1, issue_src2;
  logic          stall;
  logic          clr_req;
  logic          clr_busy;
  logic          clr_done;
  logic [1:0]    clr_state;

  vector_register_file dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_mask    (wr_mask),
    .wr_data    (wr_data),
    .rd_sel1    (rd_sel1),
    .rd_sel2    (rd_sel2),
    .rd1_data   (rd1_data),
    .rd2_data   (rd2_data),
    .issue_en   (issue_en),
    .issue_dst  (issue_dst),
    .issue_src1 (issue_src1),
    .issue_src2 (issue_src2),
    .stall      (stall),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .clr_state  (clr_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Register contents, pending flags, and position inside a bulk clear
  // (0 = not clearing, 1..RC = wiping register k-1 this cycle, RC+1 = done).
  logic [VW-1:0] m_mem [RC];
  bit            m_pend [RC];
  int            m_clr_k;

  function automatic logic [VW-1:0] m_merge(input logic [VW-1:0] old_v,
                                            input logic [VW-1:0] new_v,
                                            input logic [LANES-1:0] mask);
    logic [VW-1:0] r;
    r = old_v;
    for (int l = 0; l < LANES; l++)
      if (mask[l]) r[l*EW +: EW] = new_v[l*EW +: EW];
    return r;
  endfunction

  function automatic bit m_busy();
    return m_clr_k != 0;
  endfunction

  function automatic bit m_wr_ok();
    return wr_en && !m_busy();
  endfunction

  function automatic bit m_hazard(input logic [SB-1:0] r);
    return m_pend[r] && !(m_wr_ok() && wr_sel == r);
  endfunction

  function automatic bit m_stall();
    if (m_busy()) return 1'b1;
    if (!issue_en) return 1'b0;
    return m_hazard(issue_src1) || m_hazard(issue_src2) || m_hazard(issue_dst);
  endfunction

  function automatic logic [VW-1:0] m_read(input logic [SB-1:0] sel);
    logic [VW-1:0] v;
    v = m_mem[sel];
`ifdef VRF_WRITE_BYPASS_EN
    if (m_wr_ok() && sel == wr_sel) v = m_merge(v, wr_data, wr_mask);
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < RC; r++) begin
      m_mem[r]  = '0;
      m_pend[r] = 1'b0;
    end
    m_clr_k = 0;
  endtask

  task automatic model_step();
    bit busy, wr_ok, st;
    busy  = m_busy();
    wr_ok = m_wr_ok();
    st    = m_stall();
    if (busy) begin
      if (m_clr_k <= RC) begin
        m_mem[m_clr_k-1]  = '0;
        m_pend[m_clr_k-1] = 1'b0;
      end
      m_clr_k = (m_clr_k == RC + 1) ? 0 : m_clr_k + 1;
    end else if (clr_req) begin
      m_clr_k = 1;
    end
    if (wr_ok) begin
      m_mem[wr_sel]  = m_merge(m_mem[wr_sel], wr_data, wr_mask);
      m_pend[wr_sel] = 1'b0;
    end
    if (issue_en && !st) m_pend[issue_dst] = 1'b1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on && reset) begin
        check("rd1", rd1_data, m_read(rd_sel1));
        check("rd2", rd2_data, m_read(rd_sel2));
        check("stall", {31'd0, stall}, {31'd0, m_stall()});
        check("clr_busy", {31'd0, clr_busy}, {31'd0, m_busy()});
        check("clr_done", {31'd0, clr_done}, {31'd0, m_clr_k == RC + 1});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_sel = '0; wr_mask = '0; wr_data = '0;
    rd_sel1 = '0; rd_sel2 = '0;
    issue_en = 1'b0; issue_dst = '0; issue_src1 = '0; issue_src2 = '0;
    clr_req = 1'b0;
  endtask

  task automatic drive_write(input logic [SB-1:0] sel, input logic [LANES-1:0] mask,
                             input logic [VW-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_mask = mask; wr_data = data;
  endtask

  task automatic drive_issue(input logic [SB-1:0] dst, input logic [SB-1:0] s1,
                             input logic [SB-1:0] s2);
    issue_en = 1'b1; issue_dst = dst; issue_src1 = s1; issue_src2 = s2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    cmp_on = 1'b1;

    // Reset state
    for (int s = 0; s < 4; s++) begin
      rd_sel1 = SB'(s); rd_sel2 = SB'(s + 4);
      #1;
      check("reset_rd1", rd1_data, 32'h0);
      check("reset_rd2", rd2_data, 32'h0);
    end
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_busy", {31'd0, clr_busy}, 32'd0);
    check("reset_state", {30'd0, clr_state}, {30'd0, CLR_IDLE});

    // Masked write
    step(); drive_write(3'd3, 4'b1111, 32'h44332211);
    step(); drive_write(3'd3, 4'b0101, 32'hAABBCCDD);
    step(); wr_en = 1'b0; rd_sel1 = 3'd3;
    #1 check("masked_write", rd1_data, 32'h44BB22DD);

    // Scoreboard RAW hazard and writeback bypass of the hazard
    step(); drive_issue(3'd2, 3'd0, 3'd0);
    #1 check("issue_free", {31'd0, stall}, 32'd0);
    step(); drive_issue(3'd3, 3'd2, 3'd0);
    #1 check("raw_stall", {31'd0, stall}, 32'd1);
    drive_write(3'd2, 4'b0000, 32'hDEADBEEF);
    #1 check("wb_unstall", {31'd0, stall}, 32'd0);
    // Same-edge set and clear of register 5
    step(); drive_issue(3'd5, 3'd0, 3'd0); drive_write(3'd5, 4'b0000, 32'h0);
    #1 check("same_edge_issue", {31'd0, stall}, 32'd0);
    step(); wr_en = 1'b0; drive_issue(3'd0, 3'd0, 3'd5);
    #1 check("set_wins", {31'd0, stall}, 32'd1);
    rd_sel1 = 3'd3;
    check("mask0_no_write", rd1_data, 32'h44BB22DD);

    // Fill all registers then bulk clear
    for (int r = 0; r < RC; r++) begin
      step(); issue_en = 1'b0;
      drive_write(SB'(r), 4'b1111, $urandom() | 32'h1);
    end
    step(); wr_en = 1'b0; clr_req = 1'b1;
    step(); clr_req = 1'b0;
    for (int i = 1; i <= RC + 1; i++) begin
      if (i == 4) drive_write(3'd0, 4'b1111, 32'hFFFFFFFF);
      else wr_en = 1'b0;
      #1;
      check("clr_busy_seq", {31'd0, clr_busy}, 32'd1);
      check("clr_done_seq", {31'd0, clr_done}, (i == RC + 1) ? 32'd1 : 32'd0);
      check("clr_stall", {31'd0, stall}, 32'd1);
      step();
    end
    wr_en = 1'b0;
    #1;
    check("clr_busy_end", {31'd0, clr_busy}, 32'd0);
    check("clr_done_end", {31'd0, clr_done}, 32'd0);
    for (int s = 0; s < 4; s++) begin
      rd_sel1 = SB'(s); rd_sel2 = SB'(s + 4);
      #1;
      check("cleared_rd1", rd1_data, 32'h0);
      check("cleared_rd2", rd2_data, 32'h0);
    end

    // Reset in the middle of a clear
    step(); drive_write(3'd6, 4'b1111, 32'h12345678);
    step(); wr_en = 1'b0; clr_req = 1'b1;
    step(); clr_req = 1'b0;
    step(); step(); step();
    rd_sel1 = 3'd6;
    #1 reset = 1'b0;
    #1;
    check("midreset_busy", {31'd0, clr_busy}, 32'd0);
    check("midreset_done", {31'd0, clr_done}, 32'd0);
    check("midreset_stall", {31'd0, stall}, 32'd0);
    check("midreset_rd1", rd1_data, 32'h0);
    step(); reset = 1'b1;
    for (int i = 0; i < RC + 4; i++) begin
      #1 check("no_done_after_reset", {31'd0, clr_done}, 32'd0);
      step();
    end

    // Same-cycle read of a register being written
    drive_write(3'd1, 4'b1111, 32'h44332211);
    step(); drive_write(3'd1, 4'b0011, 32'hAABBCCDD); rd_sel1 = 3'd1;
    #1;
`ifdef VRF_WRITE_BYPASS_EN
    check("bypass_same_cycle", rd1_data, 32'h4433CCDD);
`else
    check("no_bypass_same_cycle", rd1_data, 32'h44332211);
`endif
    step(); wr_en = 1'b0;
    #1 check("write_visible_next", rd1_data, 32'h4433CCDD);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      step();
      wr_en      = 1'($urandom_range(0, 1));
      wr_sel     = SB'($urandom_range(0, RC - 1));
      wr_mask    = LANES'($urandom_range(0, 15));
      wr_data    = $urandom();
      rd_sel1    = SB'($urandom_range(0, RC - 1));
      rd_sel2    = ($urandom_range(0, 7) == 0) ? rd_sel1 : SB'($urandom_range(0, RC - 1));
      issue_en   = 1'($urandom_range(0, 1));
      issue_dst  = SB'($urandom_range(0, RC - 1));
      issue_src1 = SB'($urandom_range(0, RC - 1));
      issue_src2 = SB'($urandom_range(0, RC - 1));
      clr_req    = ($urandom_range(0, 63) == 0);
    end

    step();
    idle_inputs();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
